pipeline_stall_unit: RTL and testbench
======================================

// Module: pipeline_stall_unit
// PURPOSE
//  Decode-stage stall/flush controller for the 5-stage pipeline.
//  Detects load-use hazards that bypassing cannot cover, freezes the pipe while the
//  multi-cycle mult/div unit runs, and squashes wrong-path instructions on a taken branch.
//  Feeds PC/FD/DX/XM latch enables and nop-insert selects; sits beside the bypass controller.
//  Field map (all instruction words): op[31:27] rd[26:22] rs[21:17] rt[16:12] aluop[6:2].
// PARAMETERS
//  MD_TIMEOUT  64  cycles in MD_WAIT before forced exit with mdTimeout
// PORTS
//  clock        in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-high
//  inFD         in   32  instruction in F/D latch
//  inDX         in   32  instruction in D/X latch
//  branchTaken  in   1   X stage resolved taken branch/jump (bne,blt,jr,bex)
//  mdResultRdy  in   1   mult/div result valid (pulse)
//  stallPC      out  1   hold PC
//  stallFD      out  1   hold F/D latch
//  stallDX      out  1   hold D/X latch
//  bubbleDX     out  1   load nop (32'h0) into D/X next edge
//  bubbleXM     out  1   load nop into X/M next edge
//  flushFD      out  1   load nop into F/D next edge
//  mdStart      out  1   one-cycle start pulse to mult/div
//  mdCapture    out  1   mult/div result to be latched into X/M this edge
//  mdTimeout    out  1   sticky: a mult/div exceeded MD_TIMEOUT
// BEHAVIOUR
//  State regs: state {RUN, MD_WAIT, MD_DONE}, cnt[6:0], mdTimeout. Reset: RUN, cnt=0, mdTimeout=0;
//   all outputs 0 while reset high and in the first RUN cycle with nop inputs.
//  Outputs combinational from state+inputs; state/cnt update on rising clock.
//  Decode: lw=01000, sw=00111, bne=00010, blt=00110, jr=00100, ALU=00000, addi=00101.
//   mulDX = DX op ALU & aluop 00110; divDX = DX op ALU & aluop 00111.
//  FD source regs: rs for ALU,addi,lw,sw,bne,blt; rt for ALU except sll(00100)/sra(00101);
//   rd field as source for sw,bne,blt,jr.
//  loadUse = DX is lw & DX.rd!=0 & some FD source reg == DX.rd (r0 never hazards).
//  RUN priority (highest first):
//   1 branchTaken: flushFD=1, bubbleDX=1, no stall, no mdStart (DX is wrong path); stay RUN.
//   2 loadUse: stallPC=stallFD=1, bubbleDX=1 for exactly one cycle; stay RUN.
//   3 mulDX|divDX: mdStart=1, stallPC=stallFD=stallDX=1, bubbleXM=1; cnt<=0; ->MD_WAIT.
//   else all outputs 0.
//  MD_WAIT: stallPC=stallFD=stallDX=1, bubbleXM=1; cnt<=cnt+1.
//   mdResultRdy -> MD_DONE. Else cnt==MD_TIMEOUT-1 -> mdTimeout<=1, ->MD_DONE.
//   mdResultRdy and timeout same cycle: MD_DONE, mdTimeout not set.
//   branchTaken ignored (X holds a bubble; cannot legally assert).
//  MD_DONE (1 cycle): mdCapture=1, stalls released, DX advances; ->RUN. No mdStart, even if
//   new DX is mul/div (it is evaluated next cycle in RUN). loadUse evaluated as in RUN.
//  mdTimeout cleared only by reset. cnt saturates; never wraps within MD_WAIT.
//  Reset mid-MD_WAIT: immediately RUN, all outputs 0; mult/div abandoned.
// TESTING
//  lw r3 in DX, FD=add r5,r3,r4 -> one cycle stallPC=stallFD=bubbleDX=1, then all 0.
//  lw r0 in DX, FD reads r0 -> no stall; lw r3 DX, FD=sll r5,r4 with rt=r3 -> no stall.
//  mul in DX, mdResultRdy after 17 cycles -> mdStart 1 cycle, stalls 17 cycles, mdCapture 1.
//  mul in DX, no mdResultRdy -> exit after 64 MD_WAIT cycles, mdTimeout=1 held until reset.
//  branchTaken with lw-use in DX/FD -> flushFD=bubbleDX=1, stallPC=0.
//  reset asserted mid-MD_WAIT (cycle 5) -> outputs 0 async, state RUN after release.

Source files
------------

// File: rtl/pipeline_stall_unit.sv
// Decode-stage stall/flush controller: load-use interlock, mult/div freeze and
// wrong-path squash on a taken branch, driving the PC/FD/DX/XM latch controls.
module pipeline_stall_unit #(
  parameter int MD_TIMEOUT = 64
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [31:0] in_fd_i,
  input  logic [31:0] in_dx_i,
  input  logic        branch_taken_i,
  input  logic        md_result_rdy_i,
  output logic        stall_pc_o,
  output logic        stall_fd_o,
  output logic        stall_dx_o,
  output logic        bubble_dx_o,
  output logic        bubble_xm_o,
  output logic        flush_fd_o,
  output logic        md_start_o,
  output logic        md_capture_o,
  output logic        md_timeout_o
);

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] AOP_SLL = 5'b00100;
  localparam logic [4:0] AOP_SRA = 5'b00101;
  localparam logic [4:0] AOP_MUL = 5'b00110;
  localparam logic [4:0] AOP_DIV = 5'b00111;
  localparam logic [6:0] CNT_LAST = 7'(MD_TIMEOUT - 1);
  localparam logic [6:0] CNT_MAX  = 7'h7f;

  typedef enum logic [1:0] {RUN, MD_WAIT, MD_DONE} state_t;

  state_t     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt, fd_aluop;
  logic [4:0] dx_op, dx_rd, dx_aluop;
  logic       use_rs, use_rt, use_rd;
  logic       load_use, md_dx;
  logic       s_pc, s_fd, s_dx, b_dx, b_xm, f_fd, m_start, m_cap;

  assign fd_op    = in_fd_i[31:27];
  assign fd_rd    = in_fd_i[26:22];
  assign fd_rs    = in_fd_i[21:17];
  assign fd_rt    = in_fd_i[16:12];
  assign fd_aluop = in_fd_i[6:2];
  assign dx_op    = in_dx_i[31:27];
  assign dx_rd    = in_dx_i[26:22];
  assign dx_aluop = in_dx_i[6:2];

  assign use_rs = (fd_op == OP_ALU) || (fd_op == OP_ADDI) || (fd_op == OP_LW) ||
                  (fd_op == OP_SW)  || (fd_op == OP_BNE)  || (fd_op == OP_BLT);
  assign use_rt = (fd_op == OP_ALU) && (fd_aluop != AOP_SLL) && (fd_aluop != AOP_SRA);
  assign use_rd = (fd_op == OP_SW) || (fd_op == OP_BNE) || (fd_op == OP_BLT) ||
                  (fd_op == OP_JR);

  // r0 is hardwired zero, so a load targeting it never creates a hazard
  assign load_use = (dx_op == OP_LW) && (dx_rd != 5'd0) &&
                    ((use_rs && (fd_rs == dx_rd)) ||
                     (use_rt && (fd_rt == dx_rd)) ||
                     (use_rd && (fd_rd == dx_rd)));
  assign md_dx = (dx_op == OP_ALU) && ((dx_aluop == AOP_MUL) || (dx_aluop == AOP_DIV));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= RUN;
      cnt_q     <= 7'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    s_pc      = 1'b0;
    s_fd      = 1'b0;
    s_dx      = 1'b0;
    b_dx      = 1'b0;
    b_xm      = 1'b0;
    f_fd      = 1'b0;
    m_start   = 1'b0;
    m_cap     = 1'b0;
    case (state_q)
      RUN: begin
        if (branch_taken_i) begin
          f_fd = 1'b1;
          b_dx = 1'b1;
        end else if (load_use) begin
          s_pc = 1'b1;
          s_fd = 1'b1;
          b_dx = 1'b1;
        end else if (md_dx) begin
          m_start = 1'b1;
          s_pc    = 1'b1;
          s_fd    = 1'b1;
          s_dx    = 1'b1;
          b_xm    = 1'b1;
          cnt_d   = 7'd0;
          state_d = MD_WAIT;
        end
      end
      MD_WAIT: begin
        s_pc  = 1'b1;
        s_fd  = 1'b1;
        s_dx  = 1'b1;
        b_xm  = 1'b1;
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 7'd1;
        if (md_result_rdy_i) begin
          state_d = MD_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = MD_DONE;
        end
      end
      MD_DONE: begin
        m_cap   = 1'b1;
        state_d = RUN;
        if (load_use) begin
          s_pc = 1'b1;
          s_fd = 1'b1;
          b_dx = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are forced low for the whole time reset is held, regardless of inputs
  assign stall_pc_o   = s_pc    & ~reset_i;
  assign stall_fd_o   = s_fd    & ~reset_i;
  assign stall_dx_o   = s_dx    & ~reset_i;
  assign bubble_dx_o  = b_dx    & ~reset_i;
  assign bubble_xm_o  = b_xm    & ~reset_i;
  assign flush_fd_o   = f_fd    & ~reset_i;
  assign md_start_o   = m_start & ~reset_i;
  assign md_capture_o = m_cap   & ~reset_i;
  assign md_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipeline_stall_unit.sv
// Randomized bench for pipeline_stall_unit against a cycle-level behavioural model
// of the stall/flush rules, plus directed hazard, timeout and reset scenarios.
module tb_pipeline_stall_unit;

  localparam int MD_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_fd, in_dx;
  logic        br, rdy;
  logic        stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd;
  logic        md_start, md_capture, md_timeout;

  int checks = 0;
  int failures = 0;

  // model state: 0 = running, 1 = waiting on mult/div, 2 = capture cycle
  int m_mode = 0;
  int m_waited = 0;
  bit m_tout = 0;

  pipeline_stall_unit #(.MD_TIMEOUT(MD_TIMEOUT)) dut (
    .clock_i(clk), .reset_i(rst), .in_fd_i(in_fd), .in_dx_i(in_dx),
    .branch_taken_i(br), .md_result_rdy_i(rdy),
    .stall_pc_o(stall_pc), .stall_fd_o(stall_fd), .stall_dx_o(stall_dx),
    .bubble_dx_o(bubble_dx), .bubble_xm_o(bubble_xm), .flush_fd_o(flush_fd),
    .md_start_o(md_start), .md_capture_o(md_capture), .md_timeout_o(md_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs[8:0], exp[8:0], $time);
    end
  endtask

  function automatic logic [31:0] ins(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] aop);
    return {op, rd, rs, rt, 5'd0, aop, 2'b00};
  endfunction

  // true when instruction f reads register r as a source
  function automatic bit reads(input logic [31:0] f, input logic [4:0] r);
    logic [4:0] op, a;
    op = f[31:27];
    a  = f[6:2];
    case (op)
      5'b00000: return (f[21:17] == r) || ((a != 5'b00100) && (a != 5'b00101) && (f[16:12] == r));
      5'b00101, 5'b01000: return f[21:17] == r;
      5'b00111, 5'b00010, 5'b00110: return (f[21:17] == r) || (f[26:22] == r);
      5'b00100: return f[26:22] == r;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit hazard(input logic [31:0] f, input logic [31:0] d);
    return (d[31:27] == 5'b01000) && (d[26:22] != 5'd0) && reads(f, d[26:22]);
  endfunction

  function automatic bit is_md(input logic [31:0] d);
    return (d[31:27] == 5'b00000) && ((d[6:2] == 5'b00110) || (d[6:2] == 5'b00111));
  endfunction

  // packed as {spc, sfd, sdx, bdx, bxm, ffd, start, cap, tout}
  function automatic logic [31:0] expect_outs();
    logic [8:0] v;
    bit lu;
    v  = '0;
    lu = hazard(in_fd, in_dx);
    if (m_mode == 0) begin
      if (br)             v = 9'b000101000;
      else if (lu)        v = 9'b110100000;
      else if (is_md(in_dx)) v = 9'b111010100;
    end else if (m_mode == 1) begin
      v = 9'b111010000;
    end else begin
      v = lu ? 9'b110100010 : 9'b000000010;
    end
    v[0] = m_tout;
    return {23'd0, v};
  endfunction

  function automatic logic [31:0] dut_outs();
    return {23'd0, stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd,
            md_start, md_capture, md_timeout};
  endfunction

  task automatic model_advance();
    case (m_mode)
      0: if (!br && !hazard(in_fd, in_dx) && is_md(in_dx)) begin
           m_mode   = 1;
           m_waited = 0;
         end
      1: begin
           m_waited++;
           if (rdy) m_mode = 2;
           else if (m_waited == MD_TIMEOUT) begin
             m_tout = 1;
             m_mode = 2;
           end
         end
      default: m_mode = 0;
    endcase
  endtask

  task automatic step(input string tag, input logic [31:0] f, input logic [31:0] d,
                      input logic b, input logic r);
    @(negedge clk);
    in_fd = f;
    in_dx = d;
    br    = b;
    rdy   = r;
    #1;
    check(tag, dut_outs(), expect_outs());
    @(posedge clk);
    model_advance();
  endtask

  function automatic logic [31:0] rand_ins();
    logic [4:0] ops [8];
    logic [4:0] aops [6];
    ops  = '{5'b01000, 5'b00111, 5'b00010, 5'b00110, 5'b00100, 5'b00000, 5'b00101, 5'b11111};
    aops = '{5'b00000, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b00001};
    return ins(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), aops[$urandom_range(0, 5)]);
  endfunction

  logic [31:0] lw_r3, lw_r0, add_r3, add_r0, sll_r3, mul_i, nop;

  initial begin
    nop    = 32'h0;
    lw_r3  = ins(5'b01000, 5'd3, 5'd1, 5'd0, 5'd0);
    lw_r0  = ins(5'b01000, 5'd0, 5'd1, 5'd0, 5'd0);
    add_r3 = ins(5'b00000, 5'd5, 5'd3, 5'd4, 5'd0);
    add_r0 = ins(5'b00000, 5'd5, 5'd0, 5'd0, 5'd0);
    sll_r3 = ins(5'b00000, 5'd5, 5'd4, 5'd3, 5'b00100);
    mul_i  = ins(5'b00000, 5'd6, 5'd1, 5'd2, 5'b00110);

    rst = 1'b1; in_fd = lw_r3; in_dx = mul_i; br = 1'b1; rdy = 1'b0;
    #12;
    check("reset_outs", dut_outs(), 32'd0);
    in_fd = nop; in_dx = nop; br = 1'b0;
    @(negedge clk); rst = 1'b0;

    step("idle", nop, nop, 0, 0);
    step("loaduse", add_r3, lw_r3, 0, 0);
    step("after_lu", add_r3, nop, 0, 0);
    step("lw_r0", add_r0, lw_r0, 0, 0);
    step("sll_rt", sll_r3, lw_r3, 0, 0);
    step("br_over_lu", add_r3, lw_r3, 1, 0);

    step("md_start", nop, mul_i, 0, 0);
    for (int i = 0; i < 16; i++) step("md_wait", nop, mul_i, 0, 0);
    step("md_rdy", nop, mul_i, 0, 1);
    step("md_cap_mul", nop, mul_i, 0, 0);
    step("md_restart", nop, mul_i, 0, 0);
    for (int i = 0; i < MD_TIMEOUT + 3; i++) step("md_tout", nop, nop, 0, 0);
    step("tout_sticky", nop, nop, 0, 0);

    step("md_start2", nop, mul_i, 0, 0);
    for (int i = 0; i < MD_TIMEOUT - 1; i++) step("md_wait2", nop, mul_i, 0, 0);
    step("rdy_at_tout", add_r3, lw_r3, 0, 1);
    step("cap_lu", add_r3, lw_r3, 0, 0);

    for (int n = 0; n < 2000; n++) begin
      logic b, r;
      b = (m_mode == 1) ? 1'b0 : ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 9) == 0);
      step("rand", rand_ins(), rand_ins(), b, r);
    end

    step("md_start3", nop, mul_i, 0, 0);
    for (int i = 0; i < 4; i++) step("md_wait3", nop, mul_i, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("reset_async", dut_outs(), 32'd0);
    m_mode = 0; m_waited = 0; m_tout = 0;
    @(negedge clk); rst = 1'b0;
    in_fd = nop; in_dx = nop;
    #1 check("post_reset", dut_outs(), 32'd0);
    step("post_rst_lu", add_r3, lw_r3, 0, 0);
    step("post_rst_md", nop, mul_i, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
